// File: rtl/sobel_scan_ctrl_if.sv
// Pixel-in / edge-out stream bundle for the Sobel frame sequencer.
// The controller uses the slave view; the pixel source and edge sink use the master view.
interface sobel_scan_ctrl_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_eol;
    logic       m_eof;

    modport slave (
        input  s_valid, s_data,
        output s_ready, m_valid, m_data, m_eol, m_eof
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, m_valid, m_data, m_eol, m_eof
    );
endinterface

// File: rtl/sobel_scan_ctrl.sv
// Raster-to-3x3-window sequencer for one sobel_filter: two line buffers, window taps,
// and a valid/eol/eof output stream aligned to the filter's registered edge_out.
module sobel_scan_ctrl #(
    parameter  int IMG_W = 640,
    parameter  int IMG_H = 480,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    sobel_scan_ctrl_if.slave sif,
    output logic [7:0] p00,
    output logic [7:0] p01,
    output logic [7:0] p02,
    output logic [7:0] p10,
    output logic [7:0] p11,
    output logic [7:0] p12,
    output logic [7:0] p20,
    output logic [7:0] p21,
    output logic [7:0] p22,
    input  logic [7:0] edge_in
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    state_t         r_state;
    logic           r_busy;
    logic           r_s_ready;
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic           r_win_vld;
    logic           r_eol_p;
    logic           r_eof_p;
    logic           r_m_valid;
    logic           r_m_eol;
    logic           r_m_eof;
    logic           r_done;
    logic [7:0]     r_lb0 [IMG_W];
    logic [7:0]     r_lb1 [IMG_W];
    logic [7:0]     r_tap [3][3];

    logic           w_accept;
    logic           w_col_last;
    logic           w_row_last;
    logic           w_fill_last;
    logic           w_frame_last;

    // An abort in the same cycle as a handshake wins: the pixel is dropped with the frame.
    assign w_accept     = sif.s_valid & r_s_ready & ~abort;
    assign w_col_last   = (r_col == CW'(IMG_W - 1));
    assign w_row_last   = (r_row == RW'(IMG_H - 1));
    assign w_fill_last  = w_accept & w_col_last & (r_row == RW'(1));
    assign w_frame_last = w_accept & w_col_last & w_row_last;

    // NOTE: state and its decoded outputs share one clocked block so busy/s_ready are glitch-free flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b0;
        end else if (abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state   <= FILL;
                    r_busy    <= 1'b1;
                    r_s_ready <= 1'b1;
                end
                FILL: if (w_fill_last) r_state <= RUN;
                RUN: if (w_frame_last) begin
                    r_state   <= DRAIN;
                    r_s_ready <= 1'b0;
                end
                DRAIN: if (r_m_eof) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan counters and the two-stage marker pipeline (window valid -> filter register -> output).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_win_vld <= 1'b0;
            r_eol_p   <= 1'b0;
            r_eof_p   <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_eol   <= 1'b0;
            r_m_eof   <= 1'b0;
            r_done    <= 1'b0;
        end else if (abort || (r_state == IDLE && start)) begin
            r_col     <= '0;
            r_row     <= '0;
            r_win_vld <= 1'b0;
            r_eol_p   <= 1'b0;
            r_eof_p   <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_eol   <= 1'b0;
            r_m_eof   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_win_vld <= w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
            r_eol_p   <= w_accept & w_col_last;
            r_eof_p   <= w_frame_last;
            r_m_valid <= r_win_vld;
            r_m_eol   <= r_win_vld & r_eol_p;
            r_m_eof   <= r_win_vld & r_eof_p;
            r_done    <= r_win_vld & r_eof_p;
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Window shifts left; the new right column is {row r-2, row r-1, row r} at this column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_tap[r][c] <= 8'd0;
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_tap[r][0] <= r_tap[r][1];
                r_tap[r][1] <= r_tap[r][2];
            end
            r_tap[0][2] <= r_lb0[r_col];
            r_tap[1][2] <= r_lb1[r_col];
            r_tap[2][2] <= sif.s_data;
        end
    end

    // NOTE: line buffers carry no reset so they map to RAM; rows 0-1 of every frame rewrite them before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= sif.s_data;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign sif.s_ready = r_s_ready;
    assign sif.m_valid = r_m_valid;
    assign sif.m_data  = edge_in;
    assign sif.m_eol   = r_m_eol;
    assign sif.m_eof   = r_m_eof;

    assign p00 = r_tap[0][0];
    assign p01 = r_tap[0][1];
    assign p02 = r_tap[0][2];
    assign p10 = r_tap[1][0];
    assign p11 = r_tap[1][1];
    assign p12 = r_tap[1][2];
    assign p20 = r_tap[2][0];
    assign p21 = r_tap[2][1];
    assign p22 = r_tap[2][2];

endmodule
